// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: one outstanding instruction fetch, a one-entry decode buffer,
// and redirects from execute that flush younger work and drop stale fetch responses.
module fetch_pc_ctrl #(
  parameter int                    DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_inst,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [31:0]           if_inst,
  input  logic                  ex_resolve_valid,
  input  logic [2:0]            ex_specinst,
  input  logic [2:0]            ex_detail,
  input  logic                  ex_cmp,
  input  logic [DATA_WIDTH-1:0] ex_take_target,
  output logic                  flush_o,
  output logic [CNT_WIDTH-1:0]  redirect_cnt
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  localparam logic [2:0] SPEC_BR   = 3'd0;
  localparam logic [2:0] SPEC_JAL  = 3'd1;
  localparam logic [2:0] SPEC_JALR = 3'd2;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  discard_q, discard_d;
  logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]           if_inst_q, if_inst_d;
  logic                  flush_q, flush_d;
  logic [CNT_WIDTH-1:0]  redirect_cnt_q, redirect_cnt_d;

  logic take;
  logic redir;
  logic req_fire;

  // Same branch-outcome rule as the core's next-PC selector; funct3 010/011 never take.
  always_comb begin
    unique case (ex_detail)
      3'b000, 3'b100, 3'b110: take = ex_cmp;
      3'b001, 3'b101, 3'b111: take = ~ex_cmp;
      default:                take = 1'b0;
    endcase
  end

  assign redir = ex_resolve_valid &
                 ((ex_specinst == SPEC_JAL) | (ex_specinst == SPEC_JALR) |
                  ((ex_specinst == SPEC_BR) & take));

  // Request valid comes from state only; rst masks it so nothing is issued while held in reset.
  assign imem_req_valid = (state_q == S_REQ) & ~rst;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d        = state_q;
    pc_d           = pc_q;
    discard_d      = discard_q;
    if_pc_d        = if_pc_q;
    if_inst_d      = if_inst_q;
    flush_d        = redir;
    redirect_cnt_d = redirect_cnt_q + CNT_WIDTH'(redir);

    unique case (state_q)
      S_REQ: begin
        if (req_fire) begin
          state_d = S_WAIT;
          // A redirect in the accept cycle makes this fetch stale before it returns.
          if (redir) discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          discard_d = 1'b0;
          if (redir || discard_q) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_HOLD;
            if_pc_d   = pc_q;
            if_inst_d = imem_rsp_inst;
          end
        end else if (redir) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          state_d = S_REQ;
        end else if (if_ready) begin
          state_d = S_REQ;
          pc_d    = pc_q + DATA_WIDTH'(4);
        end
      end
      default: state_d = S_REQ;
    endcase

    // Redirect outranks every handshake: the target always replaces the PC.
    if (redir) pc_d = ex_take_target;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_REQ;
      pc_q           <= RESET_PC;
      discard_q      <= 1'b0;
      // NOTE: the decode buffer is reset too, so if_pc/if_inst read as zero out of reset.
      if_pc_q        <= '0;
      if_inst_q      <= '0;
      flush_q        <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      discard_q      <= discard_d;
      if_pc_q        <= if_pc_d;
      if_inst_q      <= if_inst_d;
      flush_q        <= flush_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign if_valid     = (state_q == S_HOLD);
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign flush_o      = flush_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule
